i2s_fifo: RTL

- Single-clock synchronous FIFO for I2S sample words, instantiated twice:
  - Tx side: register file writes (wen) feed the I2S serializer (ren).
  - Rx side: the deserializer (wen) feeds the register file (ren).
- Its full/empty outputs drive the Tx_full/Rx_empty inputs of the register-handshake controller; that controller's Tx_wen/Rx_ren pulses drive wen/ren here.
- Provides level, programmable almost-full/almost-empty thresholds, and overrun/underrun error reporting.

---
 rtl/i2s_pkg.sv | 35 +++
 rtl/i2s_fifo_mem.sv | 41 ++++
 rtl/i2s_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: data width, default FIFO depth and the FIFO status
// record reported to the register file.
package i2s_pkg;

  localparam int I2S_DATA_W     = 32;
  localparam int I2S_FIFO_DEPTH = 8;

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overrun;
    logic underrun;
  } i2s_fifo_status_t;

  function automatic i2s_fifo_status_t pack_status(
    input logic full_i,
    input logic empty_i,
    input logic almost_full_i,
    input logic almost_empty_i,
    input logic overrun_i,
    input logic underrun_i
  );
    i2s_fifo_status_t s;
    s.full         = full_i;
    s.empty        = empty_i;
    s.almost_full  = almost_full_i;
    s.almost_empty = almost_empty_i;
    s.overrun      = overrun_i;
    s.underrun     = underrun_i;
    return s;
  endfunction

endpackage

// File: rtl/i2s_fifo_mem.sv
// DEPTH x WIDTH sample storage: one write port and one registered read port.
// The array itself is not reset; only the read register is.
module i2s_fifo_mem
  import i2s_pkg::*;
#(
  parameter int DEPTH = I2S_FIFO_DEPTH,
  parameter int WIDTH = I2S_DATA_W,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write port
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register holds its value until the next accepted read
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= {WIDTH{1'b0}};
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/i2s_fifo.sv
// Single-clock I2S sample FIFO with level, almost thresholds and error flags.
// Define I2S_FIFO_STICKY_EN to make overrun/underrun sticky until clr_flags.
module i2s_fifo
  import i2s_pkg::*;
#(
  parameter int DEPTH    = I2S_FIFO_DEPTH,
  parameter int WIDTH    = I2S_DATA_W,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                     pclk,
  input  logic                     preset,
  input  logic                     wen,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     ren,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overrun,
  output logic                     underrun,
  input  logic                     clr_flags
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overrun_q, overrun_d;
  logic          underrun_q, underrun_d;
  logic          wr_acc_s, rd_acc_s;
  logic          ov_ev_s, un_ev_s;
  logic          mem_we_s, mem_re_s;
  i2s_fifo_status_t status_s;

  // Status decoded straight from the level register, no extra cycle
  always_comb begin
    status_s = pack_status(level_q == DEPTH_L,
                           level_q == {LW{1'b0}},
                           level_q >= AF_L,
                           level_q <= AE_L,
                           overrun_q,
                           underrun_q);
  end

  // Accept decisions and next-state for pointers, level and error flags
  always_comb begin
    wr_acc_s = wen && !status_s.full;
    rd_acc_s = ren && !status_s.empty;
    ov_ev_s  = wen && status_s.full;
    un_ev_s  = ren && status_s.empty;
    mem_we_s = wr_acc_s && !preset;
    mem_re_s = rd_acc_s && !preset;

    wr_ptr_d = wr_acc_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_acc_s ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({wr_acc_s, rd_acc_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

`ifdef I2S_FIFO_STICKY_EN
    // A new error outranks a coincident clear
    overrun_d  = ov_ev_s || (overrun_q && !clr_flags);
    underrun_d = un_ev_s || (underrun_q && !clr_flags);
`else
    overrun_d  = ov_ev_s;
    underrun_d = un_ev_s;
`endif
  end

`ifndef I2S_FIFO_STICKY_EN
  logic unused_clr_flags_s;
  assign unused_clr_flags_s = clr_flags;
`endif

  // State registers; reset wins over any same-cycle request
  always_ff @(posedge pclk) begin
    if (preset) begin
      wr_ptr_q   <= {AW{1'b0}};
      rd_ptr_q   <= {AW{1'b0}};
      level_q    <= {LW{1'b0}};
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  i2s_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (pclk),
    .rst_i   (preset),
    .we_i    (mem_we_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .re_i    (mem_re_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign full         = status_s.full;
  assign empty        = status_s.empty;
  assign almost_full  = status_s.almost_full;
  assign almost_empty = status_s.almost_empty;
  assign overrun      = status_s.overrun;
  assign underrun     = status_s.underrun;
  assign level        = level_q;

endmodule
